// File: rtl/flexi_core4_pkg.sv
// flexi_core4_pkg
// Shared widths, opcode encoding and skip-condition codes for the
// flexi_core4 4-bit accumulator core and its ALU.
package flexi_core4_pkg;

    localparam int DATA_LEN  = 4;   // datapath and port width
    localparam int PC_LEN    = 7;   // program counter width (128-entry ROM)
    localparam int INSTR_LEN = 8;   // instruction width
    localparam int NREGS     = 8;   // general registers R0..R7

    // Bit 7 set marks an unconditional BRANCH; bits 6:0 are the target.
    localparam int BRANCH_BIT = 7;

    // Opcode field instr[6:4] when the BRANCH bit is clear.
    typedef enum logic [2:0] {
        OP_LDI    = 3'd0,
        OP_ADDI   = 3'd1,
        OP_ADDSUB = 3'd2,   // x[3]=0 ADD r, x[3]=1 SUB r
        OP_LOGIC  = 3'd3,   // x[3]=0 NAND r, x[3]=1 XOR r
        OP_LDST   = 3'd4,   // x[3]=0 LD r, x[3]=1 ST r
        OP_IO     = 3'd5,   // x[3]=0 IN, x[3]=1 OUT
        OP_SKIP   = 3'd6,
        OP_OUTI   = 3'd7
    } opcode_e;

    // Skip-condition select x[1:0]; x[2] inverts the selected condition.
    localparam logic [1:0] SKIP_Z      = 2'd0;
    localparam logic [1:0] SKIP_N      = 2'd1;
    localparam logic [1:0] SKIP_C      = 2'd2;
    localparam logic [1:0] SKIP_ALWAYS = 2'd3;

endpackage

// File: rtl/flexi_core4_alu.sv
// flexi_core4_alu
// Purely combinational ALU for the accumulator core.
// Ports:
//   acc       - current accumulator
//   operand   - immediate, register value or input port (selected by top)
//   opcode    - decoded opcode
//   sub_sel   - instruction bit x[3] (picks SUB/XOR over ADD/NAND)
//   carry_in  - current carry flag, passed through when C is untouched
//   result    - next accumulator value for ops that write ACC
//   carry_out - next carry flag (equals carry_in unless ADDI/ADD/SUB)
module flexi_core4_alu
    import flexi_core4_pkg::*;
(
    input  logic [DATA_LEN-1:0] acc,
    input  logic [DATA_LEN-1:0] operand,
    input  opcode_e             opcode,
    input  logic                sub_sel,
    input  logic                carry_in,
    output logic [DATA_LEN-1:0] result,
    output logic                carry_out
);

    logic [DATA_LEN:0] sum_s;
    logic [DATA_LEN:0] diff_s;

    // Compute the opcode result; the extra MSB of the subtraction is the borrow.
    always_comb begin
        sum_s     = {1'b0, acc} + {1'b0, operand};
        diff_s    = {1'b0, acc} - {1'b0, operand};
        result    = acc;
        carry_out = carry_in;
        case (opcode)
            OP_LDI: begin
                result = operand;
            end
            OP_ADDI: begin
                result    = sum_s[DATA_LEN-1:0];
                carry_out = sum_s[DATA_LEN];
            end
            OP_ADDSUB: begin
                if (sub_sel) begin
                    result    = diff_s[DATA_LEN-1:0];
                    carry_out = ~diff_s[DATA_LEN];   // C = no-borrow
                end else begin
                    result    = sum_s[DATA_LEN-1:0];
                    carry_out = sum_s[DATA_LEN];
                end
            end
            OP_LOGIC: begin
                if (sub_sel) begin
                    result = acc ^ operand;
                end else begin
                    result = ~(acc & operand);
                end
            end
            OP_LDST, OP_IO: begin
                result = operand;
            end
            default: begin
                result    = acc;
                carry_out = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/flexi_core4.sv
// flexi_core4
// 4-bit accumulator micro-processor: 7-bit PC, 8-bit instructions from an
// external ROM, eight 4-bit registers, one input port and a registered
// output port. One instruction executes per rising edge of CLK.
// Ports:
//   CLK   - clock, all state updates on the rising edge
//   RST   - synchronous active-high reset (overrides any instruction)
//   INSTR - instruction at ROM[PC], presented combinationally from PC
//   IPORT - input port, sampled on the edge executing IN
//   PC    - registered program counter
//   OPORT - registered output port
module flexi_core4
    import flexi_core4_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [INSTR_LEN-1:0] INSTR,
    input  logic [DATA_LEN-1:0]  IPORT,
    output logic [PC_LEN-1:0]    PC,
    output logic [DATA_LEN-1:0]  OPORT
);

    logic [PC_LEN-1:0]   pc_r;
    logic [DATA_LEN-1:0] acc_r;
    logic                c_r;
    logic [DATA_LEN-1:0] regs_r [NREGS];
    logic [DATA_LEN-1:0] oport_r;

    logic                is_branch_s;
    opcode_e             opcode_s;
    logic [3:0]          x_s;
    logic [2:0]          reg_idx_s;
    logic [DATA_LEN-1:0] operand_s;
    logic [DATA_LEN-1:0] alu_result_s;
    logic                alu_carry_s;
    logic                skip_cond_s;
    logic [PC_LEN-1:0]   pc_next_s;
    logic                acc_we_s;
    logic                c_we_s;
    logic                reg_we_s;
    logic                oport_we_s;
    logic [DATA_LEN-1:0] oport_next_s;

    assign PC    = pc_r;
    assign OPORT = oport_r;

    // Split the instruction word into its fields.
    always_comb begin
        is_branch_s = INSTR[BRANCH_BIT];
        opcode_s    = opcode_e'(INSTR[6:4]);
        x_s         = INSTR[3:0];
        reg_idx_s   = INSTR[2:0];
    end

    // ALU operand: immediate for LDI/ADDI, the input port for IN, else R[r].
    always_comb begin
        case (opcode_s)
            OP_LDI, OP_ADDI: operand_s = x_s;
            OP_IO:           operand_s = IPORT;
            default:         operand_s = regs_r[reg_idx_s];
        endcase
    end

    flexi_core4_alu u_alu (
        .acc       (acc_r),
        .operand   (operand_s),
        .opcode    (opcode_s),
        .sub_sel   (x_s[3]),
        .carry_in  (c_r),
        .result    (alu_result_s),
        .carry_out (alu_carry_s)
    );

    // Evaluate the SKIP condition on the current flags; x[2] inverts it.
    always_comb begin
        case (x_s[1:0])
            SKIP_Z:      skip_cond_s = (acc_r == 4'd0);
            SKIP_N:      skip_cond_s = acc_r[DATA_LEN-1];
            SKIP_C:      skip_cond_s = c_r;
            SKIP_ALWAYS: skip_cond_s = 1'b1;
            default:     skip_cond_s = 1'b0;
        endcase
        skip_cond_s = skip_cond_s ^ x_s[2];
    end

    // Next-PC selection and per-instruction write enables.
    always_comb begin
        pc_next_s    = pc_r + 7'd1;
        acc_we_s     = 1'b0;
        c_we_s       = 1'b0;
        reg_we_s     = 1'b0;
        oport_we_s   = 1'b0;
        oport_next_s = acc_r;
        if (is_branch_s) begin
            pc_next_s = INSTR[PC_LEN-1:0];
        end else begin
            case (opcode_s)
                OP_LDI: begin
                    acc_we_s = 1'b1;
                end
                OP_ADDI, OP_ADDSUB: begin
                    acc_we_s = 1'b1;
                    c_we_s   = 1'b1;
                end
                OP_LOGIC: begin
                    acc_we_s = 1'b1;
                end
                OP_LDST: begin
                    acc_we_s = ~x_s[3];
                    reg_we_s = x_s[3];
                end
                OP_IO: begin
                    acc_we_s   = ~x_s[3];
                    oport_we_s = x_s[3];
                end
                OP_SKIP: begin
                    if (skip_cond_s) begin
                        pc_next_s = pc_r + 7'd2;
                    end else begin
                        pc_next_s = pc_r + 7'd1;
                    end
                end
                OP_OUTI: begin
                    oport_we_s   = 1'b1;
                    oport_next_s = x_s;
                end
                default: begin
                    pc_next_s = pc_r + 7'd1;
                end
            endcase
        end
    end

    // Architectural state update; reset takes priority over execution.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r    <= 7'd0;
            acc_r   <= 4'd0;
            c_r     <= 1'b0;
            oport_r <= 4'd0;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 4'd0;
            end
        end else begin
            pc_r <= pc_next_s;
            if (acc_we_s) begin
                acc_r <= alu_result_s;
            end
            if (c_we_s) begin
                c_r <= alu_carry_s;
            end
            if (reg_we_s) begin
                regs_r[reg_idx_s] <= acc_r;
            end
            if (oport_we_s) begin
                oport_r <= oport_next_s;
            end
        end
    end

endmodule

// File: tb/tb_flexi_core4.sv
// tb_flexi_core4
// Directed bench for flexi_core4. Each step drives one instruction, pushes
// the expected PC/OPORT after the executing edge onto a scoreboard queue,
// and pops/compares it one time unit after that edge. ACC, C and the
// register file are observed indirectly through OUT and SKIP.
module tb_flexi_core4;
    import flexi_core4_pkg::*;

    typedef struct {
        string                tag;
        logic [PC_LEN-1:0]    pc;
        logic [DATA_LEN-1:0]  op;
    } exp_t;

    logic                 CLK;
    logic                 RST;
    logic [INSTR_LEN-1:0] INSTR;
    logic [DATA_LEN-1:0]  IPORT;
    logic [PC_LEN-1:0]    PC;
    logic [DATA_LEN-1:0]  OPORT;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_bad;

    flexi_core4 dut (
        .CLK   (CLK),
        .RST   (RST),
        .INSTR (INSTR),
        .IPORT (IPORT),
        .PC    (PC),
        .OPORT (OPORT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_one();
        exp_t e;
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_bad++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            assert (PC === e.pc) else begin
                n_bad++;
                $error("FAIL %s.pc: observed %0d expected %0d", e.tag, PC, e.pc);
            end
            n_cmp++;
            assert (OPORT === e.op) else begin
                n_bad++;
                $error("FAIL %s.oport: observed %0h expected %0h", e.tag, OPORT, e.op);
            end
        end
    endtask

    task automatic step(input logic [7:0] instr, input logic [3:0] iport,
                        input logic rst, input string tag,
                        input logic [6:0] epc, input logic [3:0] eop);
        exp_t e;
        INSTR = instr;
        IPORT = iport;
        RST   = rst;
        e.tag = tag;
        e.pc  = epc;
        e.op  = eop;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        check_one();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST   = 1'b1;
        INSTR = 8'h05;
        IPORT = 4'h0;

        // Reset held two edges, then PC counts.
        step(8'h05, 4'h0, 1'b1, "rst1", 7'd0, 4'h0);
        step(8'h05, 4'h0, 1'b1, "rst2", 7'd0, 4'h0);
        step(8'h00, 4'h0, 1'b0, "cnt1", 7'd1, 4'h0);
        step(8'h00, 4'h0, 1'b0, "cnt2", 7'd2, 4'h0);
        step(8'h00, 4'h0, 1'b0, "cnt3", 7'd3, 4'h0);

        // LDI 7, OUT, OUTI 3.
        step(8'h07, 4'h0, 1'b0, "ldi7",  7'd4, 4'h0);
        step(8'h58, 4'h0, 1'b0, "out7",  7'd5, 4'h7);
        step(8'h73, 4'h0, 1'b0, "outi3", 7'd6, 4'h3);

        // IN 9, ST R2, ADDI 8 -> ACC=1 C=1.
        step(8'h50, 4'h9, 1'b0, "in9",   7'd7,  4'h3);
        step(8'h4A, 4'h0, 1'b0, "st_r2", 7'd8,  4'h3);
        step(8'h18, 4'h0, 1'b0, "addi8", 7'd9,  4'h3);
        step(8'h58, 4'h0, 1'b0, "out1",  7'd10, 4'h1);
        step(8'h62, 4'h0, 1'b0, "skc1",  7'd12, 4'h1);
        // SUB R2 -> ACC=8 C=0.
        step(8'h2A, 4'h0, 1'b0, "sub_r2", 7'd13, 4'h1);
        step(8'h62, 4'h0, 1'b0, "skc0",   7'd14, 4'h1);
        step(8'h66, 4'h0, 1'b0, "sknc",   7'd16, 4'h1);
        step(8'h58, 4'h0, 1'b0, "out8",   7'd17, 4'h8);

        // Skip conditions.
        step(8'h00, 4'h0, 1'b0, "ldi0",  7'd18, 4'h8);
        step(8'h60, 4'h0, 1'b0, "skz_t", 7'd20, 4'h8);
        step(8'h05, 4'h0, 1'b0, "ldi5",  7'd21, 4'h8);
        step(8'h60, 4'h0, 1'b0, "skz_f", 7'd22, 4'h8);
        step(8'h64, 4'h0, 1'b0, "sknz",  7'd24, 4'h8);
        step(8'h61, 4'h0, 1'b0, "skn_f", 7'd25, 4'h8);
        step(8'h0C, 4'h0, 1'b0, "ldic",  7'd26, 4'h8);
        step(8'h61, 4'h0, 1'b0, "skn_t", 7'd28, 4'h8);
        step(8'h63, 4'h0, 1'b0, "ska",   7'd30, 4'h8);
        step(8'h67, 4'h0, 1'b0, "sknev", 7'd31, 4'h8);

        // Logic, ADD, LD; LD must leave C alone.
        step(8'h03, 4'h0, 1'b0, "ldi3",    7'd32, 4'h8);
        step(8'h4D, 4'h0, 1'b0, "st_r5",   7'd33, 4'h8);
        step(8'h0C, 4'h0, 1'b0, "ldic2",   7'd34, 4'h8);
        step(8'h3D, 4'h0, 1'b0, "xor_r5",  7'd35, 4'h8);
        step(8'h58, 4'h0, 1'b0, "outf",    7'd36, 4'hF);
        step(8'h35, 4'h0, 1'b0, "nand_r5", 7'd37, 4'hF);
        step(8'h25, 4'h0, 1'b0, "add_r5",  7'd38, 4'hF);
        step(8'h11, 4'h0, 1'b0, "addi1",   7'd39, 4'hF);
        step(8'h42, 4'h0, 1'b0, "ld_r2",   7'd40, 4'hF);
        step(8'h58, 4'h0, 1'b0, "out9",    7'd41, 4'h9);
        step(8'h62, 4'h0, 1'b0, "skc_ld",  7'd43, 4'h9);

        // Advance to 0x35 with no-effect skips, then page change.
        for (int i = 0; i < 10; i++) begin
            step(8'h67, 4'h0, 1'b0, "walk", 7'(44 + i), 4'h9);
        end
        step(8'h80, 4'h0, 1'b0, "br0",     7'd0, 4'h9);
        step(8'h58, 4'h0, 1'b0, "out_pg",  7'd1, 4'h9);
        step(8'h45, 4'h0, 1'b0, "ld_r5",   7'd2, 4'h9);
        step(8'h58, 4'h0, 1'b0, "out_r5",  7'd3, 4'h3);

        // PC wrap and SKIP at the top of the ROM.
        step(8'hFF, 4'h0, 1'b0, "br127",   7'd127, 4'h3);
        step(8'h00, 4'h0, 1'b0, "wrap",    7'd0,   4'h3);
        step(8'hFE, 4'h0, 1'b0, "br126",   7'd126, 4'h3);
        step(8'h63, 4'h0, 1'b0, "sk126",   7'd0,   4'h3);
        step(8'hFF, 4'h0, 1'b0, "br127b",  7'd127, 4'h3);
        step(8'h63, 4'h0, 1'b0, "sk127",   7'd1,   4'h3);

        // Reset during a SKIP clears PC, ACC, C, regs and OPORT.
        step(8'h06, 4'h0, 1'b0, "ldi6",    7'd2, 4'h3);
        step(8'h7A, 4'h0, 1'b0, "outia",   7'd3, 4'hA);
        step(8'h63, 4'h0, 1'b1, "rst_sk",  7'd0, 4'h0);
        step(8'h60, 4'h0, 1'b0, "skz_rst", 7'd2, 4'h0);
        step(8'h45, 4'h0, 1'b0, "ld_r5z",  7'd3, 4'h0);
        step(8'h60, 4'h0, 1'b0, "skz_reg", 7'd5, 4'h0);
        step(8'h62, 4'h0, 1'b0, "skc_rst", 7'd6, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
